mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port word memory (address/dataIn/wEn/memOut) between the
//  instruction-fetch port and the load/store data port of the RISC-V core.
//  Serialises requests, holds the memory address stable for MEM_LAT cycles and
//  returns registered read data/acks to the winning requester.
//  Data port has priority; a starvation counter guarantees fetch forward progress.
// PARAMETERS
//  ADDR_W      32  word address width (memory is word-addressed: address i = word i)
//  DATA_W      32  data word width
//  MEM_LAT     1   cycles the address must be held before memOut is sampled (>=1)
//  STARVE_MAX  4   consecutive fetch losses before fetch is forced to win (>=1)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  ifReq       in   1       fetch request (read only)
//  ifAddr      in   ADDR_W  fetch word address
//  ifGnt       out  1       fetch request accepted this cycle
//  ifValid     out  1       1-cycle pulse: ifRdata valid
//  ifRdata     out  DATA_W  fetch read data
//  dReq        in   1       data request
//  dWe         in   1       1 = store, 0 = load
//  dAddr       in   ADDR_W  data word address
//  dWdata      in   DATA_W  store data
//  dGnt        out  1       data request accepted this cycle
//  dValid      out  1       1-cycle pulse: load data valid / store complete
//  dRdata      out  DATA_W  load data (unchanged on stores)
//  memAddress  out  ADDR_W  to memory address
//  memDataIn   out  DATA_W  to memory dataIn
//  memWEn      out  1       to memory wEn
//  memOut      in   DATA_W  from memory (combinational read of memAddress)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE, cnt/starve=0, all outputs 0
//    (ifRdata/dRdata cleared). Reset mid-ACCESS abandons the access: no write
//    issued, no valid pulse, no later gnt/valid for it.
//  - States: IDLE -> ACCESS -> RESP -> (ACCESS | IDLE).
//  - Arbitration only in IDLE and RESP. gnt is combinational, same cycle as req;
//    at most one gnt per cycle. Winner's addr/we/wdata are latched at that edge;
//    requester may drop or change inputs after the gnt cycle.
//  - Priority: dReq wins, except when starve==STARVE_MAX and ifReq=1 -> fetch wins.
//    starve +1 (saturating) on every arbitration where ifReq=1 and fetch loses;
//    cleared to 0 when fetch is granted; unchanged when ifReq=0.
//  - ACCESS lasts exactly MEM_LAT cycles: memAddress/memDataIn = latched values.
//    memWEn=1 only in the final ACCESS cycle, and only for a store (single write).
//    Final ACCESS edge: memOut captured into owner's rdata (load/fetch only).
//  - RESP: owner's valid=1 for this one cycle; memWEn=0; a new request may be
//    granted in the same cycle (back-to-back, MEM_LAT+1 cycles per access).
//  - Latency: gnt in cycle N -> valid in cycle N+MEM_LAT+1.
//  - IDLE: memAddress=0, memWEn=0, memDataIn=0; no req -> stay IDLE.
//  - Simultaneous ifReq+dReq: one grant only; loser must hold req, re-arbitrated in RESP.
//  - rdata registers hold their value until the next capture for that port.
// STRUCTURE
//  - Package mem_arb_pkg: state enum {IDLE,ACCESS,RESP}, owner encoding
//    {OWN_IF,OWN_D}, default widths.
//  - Sub-module mem_arb_prio: priority + starvation counter (inputs ifReq, dReq,
//    arbEn; outputs selIf, selD); top holds FSM, latency counter, latches.
// TESTING
//  1 Fetch only, MEM_LAT=1: ifReq, ifAddr=5, mem[5]=0x55 -> ifGnt cyc0, ifValid cyc2, ifRdata=0x55.
//  2 Store then load: dWe=1 addr=3 wdata=0xA5 -> memWEn one cycle, dValid; load addr=3 -> dRdata=0xA5.
//  3 Both req every cycle, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF...; ifGnt never misses >4 rounds.
//  4 MEM_LAT=3: load addr=7 -> memAddress=7 held 3 cycles, dValid exactly 4 cycles after dGnt.
//  5 rst=1 during ACCESS of a store addr=9 -> memWEn never 1, mem[9] unchanged, no dValid; IDLE next cycle.
//  6 Sweep: store i to addr i for i=0..31, then load all -> every dRdata==i, no gnt to idle port.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_checker.sv
// Protocol invariants of the memory port arbiter, observed from its ports and state.
module mem_arb_checker
    import mem_arb_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input arb_state_e state,
    input logic       ifGnt,
    input logic       dGnt,
    input logic       ifValid,
    input logic       dValid,
    input logic       memWEn
);

    a_one_gnt: assert property (@(posedge clk) disable iff (rst) !(ifGnt && dGnt));

    a_one_valid: assert property (@(posedge clk) disable iff (rst) !(ifValid && dValid));

    a_gnt_when_arb: assert property (@(posedge clk) disable iff (rst)
        (ifGnt || dGnt) |-> (state == IDLE || state == RESP));

    a_valid_in_resp: assert property (@(posedge clk) disable iff (rst)
        (ifValid || dValid) |-> (state == RESP));

    a_wen_in_access: assert property (@(posedge clk) disable iff (rst)
        memWEn |-> (state == ACCESS));

endmodule

// File: rtl/mem_arb_prio.sv
// Fixed data-port priority with a fetch starvation counter that forces a
// fetch win after STARVE_MAX consecutive losses.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ifReq,
    input  logic dReq,
    input  logic arbEn,
    output logic selIf,
    output logic selD
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_r;
    logic          force_if_s;

    // Winner selection for the current arbitration slot.
    always_comb begin
        force_if_s = (starve_r == STARVE_LIM);
        selIf      = 1'b0;
        selD       = 1'b0;
        if (arbEn) begin
            if (ifReq && (force_if_s || !dReq)) begin
                selIf = 1'b1;
            end else if (dReq) begin
                selD = 1'b1;
            end else begin
                selIf = 1'b0;
                selD  = 1'b0;
            end
        end else begin
            selIf = 1'b0;
            selD  = 1'b0;
        end
    end

    // Count arbitrations a waiting fetch has lost; a fetch grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_r <= {SW{1'b0}};
        end else if (selIf) begin
            starve_r <= {SW{1'b0}};
        end else if (selD && ifReq && (starve_r != STARVE_LIM)) begin
            starve_r <= starve_r + SW'(1'b1);
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store:
// serialises requests, holds the address for MEM_LAT cycles, returns registered data.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifGnt,
    output logic              ifValid,
    output logic [DATA_W-1:0] ifRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dGnt,
    output logic              dValid,
    output logic [DATA_W-1:0] dRdata,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memDataIn,
    output logic              memWEn,
    input  logic [DATA_W-1:0] memOut
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST_CNT     = CW'(MEM_LAT - 1);
    // Only meaningful when MEM_LAT > 1; unreachable otherwise.
    localparam logic [CW-1:0] PRE_LAST_CNT = CW'(MEM_LAT - 2);
    localparam logic          SINGLE_CYC   = (MEM_LAT == 1);

    arb_state_e        state_r, state_s;
    arb_owner_e        owner_r, owner_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_din_r, mem_din_s;
    logic              mem_wen_r, mem_wen_s;
    logic              if_valid_r, if_valid_s;
    logic              d_valid_r, d_valid_s;
    logic [DATA_W-1:0] if_rdata_r, d_rdata_r;
    logic              cap_if_s, cap_d_s;
    logic              arb_en_s, sel_if_s, sel_d_s;

    assign arb_en_s = (state_r == IDLE) || (state_r == RESP);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk   (clk),
        .rst   (rst),
        .ifReq (ifReq),
        .dReq  (dReq),
        .arbEn (arb_en_s),
        .selIf (sel_if_s),
        .selD  (sel_d_s)
    );

    // Next state, latched request and the memory-side values for the next cycle.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        cnt_s      = cnt_r;
        we_s       = we_r;
        mem_addr_s = {ADDR_W{1'b0}};
        mem_din_s  = {DATA_W{1'b0}};
        mem_wen_s  = 1'b0;
        if_valid_s = 1'b0;
        d_valid_s  = 1'b0;
        cap_if_s   = 1'b0;
        cap_d_s    = 1'b0;
        case (state_r)
            IDLE, RESP: begin
                if (sel_if_s) begin
                    state_s    = ACCESS;
                    owner_s    = OWN_IF;
                    cnt_s      = {CW{1'b0}};
                    we_s       = 1'b0;
                    mem_addr_s = ifAddr;
                end else if (sel_d_s) begin
                    state_s    = ACCESS;
                    owner_s    = OWN_D;
                    cnt_s      = {CW{1'b0}};
                    we_s       = dWe;
                    mem_addr_s = dAddr;
                    mem_din_s  = dWdata;
                    mem_wen_s  = dWe && SINGLE_CYC;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == LAST_CNT) begin
                    state_s    = RESP;
                    cnt_s      = {CW{1'b0}};
                    if_valid_s = (owner_r == OWN_IF);
                    d_valid_s  = (owner_r == OWN_D);
                    cap_if_s   = (owner_r == OWN_IF);
                    cap_d_s    = (owner_r == OWN_D) && !we_r;
                end else begin
                    cnt_s      = cnt_r + CW'(1'b1);
                    mem_addr_s = mem_addr_r;
                    mem_din_s  = mem_din_r;
                    // Write strobe lands only in the final hold cycle.
                    mem_wen_s  = we_r && (cnt_r == PRE_LAST_CNT);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset abandons any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            owner_r    <= OWN_IF;
            cnt_r      <= {CW{1'b0}};
            we_r       <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= {DATA_W{1'b0}};
            mem_wen_r  <= 1'b0;
            if_valid_r <= 1'b0;
            d_valid_r  <= 1'b0;
            if_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            cnt_r      <= cnt_s;
            we_r       <= we_s;
            mem_addr_r <= mem_addr_s;
            mem_din_r  <= mem_din_s;
            mem_wen_r  <= mem_wen_s;
            if_valid_r <= if_valid_s;
            d_valid_r  <= d_valid_s;
            if (cap_if_s) begin
                if_rdata_r <= memOut;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (cap_d_s) begin
                d_rdata_r <= memOut;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign ifGnt      = sel_if_s;
    assign dGnt       = sel_d_s;
    assign ifValid    = if_valid_r;
    assign dValid     = d_valid_r;
    assign ifRdata    = if_rdata_r;
    assign dRdata     = d_rdata_r;
    assign memAddress = mem_addr_r;
    assign memDataIn  = mem_din_r;
    assign memWEn     = mem_wen_r;

    mem_arb_checker u_chk (
        .clk     (clk),
        .rst     (rst),
        .state   (state_r),
        .ifGnt   (sel_if_s),
        .dGnt    (sel_d_s),
        .ifValid (if_valid_r),
        .dValid  (d_valid_r),
        .memWEn  (mem_wen_r)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (MEM_LAT=1 and MEM_LAT=3) each with a word memory model.
module tb_mem_port_arbiter;

    localparam int NU = 2;

    typedef struct {
        int          unit;
        logic        is_if;
        logic [31:0] data;
        longint      due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [NU];
    logic        if_req [NU];
    logic [31:0] if_addr [NU];
    logic        if_gnt [NU];
    logic        if_valid [NU];
    logic [31:0] if_rdata [NU];
    logic        d_req [NU];
    logic        d_we [NU];
    logic [31:0] d_addr [NU];
    logic [31:0] d_wdata [NU];
    logic        d_gnt [NU];
    logic        d_valid [NU];
    logic [31:0] d_rdata [NU];
    logic [31:0] mem_address [NU];
    logic [31:0] mem_data_in [NU];
    logic        mem_wen [NU];
    logic [31:0] mem_out [NU];
    logic [31:0] mem [NU][64];
    logic        mem_ready;
    longint      cyc = 0;
    int          wen_cnt [NU];
    logic [31:0] d_hold [NU];
    exp_t        sbq [$];
    bit          glog [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_l1 (
        .clk(clk), .rst(rst[0]),
        .ifReq(if_req[0]), .ifAddr(if_addr[0]), .ifGnt(if_gnt[0]),
        .ifValid(if_valid[0]), .ifRdata(if_rdata[0]),
        .dReq(d_req[0]), .dWe(d_we[0]), .dAddr(d_addr[0]), .dWdata(d_wdata[0]),
        .dGnt(d_gnt[0]), .dValid(d_valid[0]), .dRdata(d_rdata[0]),
        .memAddress(mem_address[0]), .memDataIn(mem_data_in[0]),
        .memWEn(mem_wen[0]), .memOut(mem_out[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_l3 (
        .clk(clk), .rst(rst[1]),
        .ifReq(if_req[1]), .ifAddr(if_addr[1]), .ifGnt(if_gnt[1]),
        .ifValid(if_valid[1]), .ifRdata(if_rdata[1]),
        .dReq(d_req[1]), .dWe(d_we[1]), .dAddr(d_addr[1]), .dWdata(d_wdata[1]),
        .dGnt(d_gnt[1]), .dValid(d_valid[1]), .dRdata(d_rdata[1]),
        .memAddress(mem_address[1]), .memDataIn(mem_data_in[1]),
        .memWEn(mem_wen[1]), .memOut(mem_out[1])
    );

    assign mem_out[0] = mem[0][mem_address[0][5:0]];
    assign mem_out[1] = mem[1][mem_address[1][5:0]];

    function automatic logic [31:0] init_val(input int k);
        case (k)
            5:       return 32'h0000_0055;
            7:       return 32'h0000_0077;
            9:       return 32'h0000_0099;
            default: return 32'h1000_0000 + k;
        endcase
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: preloaded on the first edge, then written by memWEn.
    always @(posedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (!mem_ready) begin
                for (int k = 0; k < 64; k++) mem[u][k] <= init_val(k);
            end else if (mem_wen[u]) begin
                mem[u][mem_address[u][5:0]] <= mem_data_in[u];
            end
        end
    end

    // Monitor: grant sanity, write-strobe counting, scoreboard compare on valid.
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (mem_wen[u]) wen_cnt[u] <= wen_cnt[u] + 1;
            if (if_gnt[u] || d_gnt[u]) begin
                chk("gnt_exclusive", {31'd0, if_gnt[u] & d_gnt[u]}, 32'd0);
                if (if_gnt[u]) chk("if_gnt_has_req", {31'd0, if_req[u]}, 32'd1);
                if (d_gnt[u]) chk("d_gnt_has_req", {31'd0, d_req[u]}, 32'd1);
                if (u == 0) glog.push_back(if_gnt[u]);
            end
            if (if_valid[u] || d_valid[u]) begin
                if (sbq.size() == 0) begin
                    fail_evt("unexpected_valid", $sformatf("unit %0d if=%0b d=%0b", u, if_valid[u], d_valid[u]));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("valid_unit", u, e.unit);
                    chk("valid_port_if", {31'd0, if_valid[u]}, {31'd0, e.is_if});
                    chk("valid_port_d", {31'd0, d_valid[u]}, {31'd0, !e.is_if});
                    chk("rdata", if_valid[u] ? if_rdata[u] : d_rdata[u], e.data);
                    chk("valid_latency", cyc[31:0], e.due[31:0]);
                end
            end
        end
    end

    task automatic d_txn(input int u, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] ld_exp, input bit want_resp);
        int   n;
        exp_t e;
        d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = addr; d_wdata[u] = wdata;
        n = 0;
        @(negedge clk);
        while (!d_gnt[u] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!d_gnt[u]) begin
            fail_evt("d_gnt_timeout", $sformatf("unit %0d addr %0d", u, addr));
        end else if (want_resp) begin
            if (!we) d_hold[u] = ld_exp;
            e.unit = u; e.is_if = 1'b0; e.data = d_hold[u]; e.due = cyc + lat_of(u) + 1;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        d_req[u] = 1'b0;
    endtask

    task automatic if_txn(input int u, input logic [31:0] addr, input logic [31:0] exp_data);
        int   n;
        exp_t e;
        if_req[u] = 1'b1; if_addr[u] = addr;
        n = 0;
        @(negedge clk);
        while (!if_gnt[u] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!if_gnt[u]) begin
            fail_evt("if_gnt_timeout", $sformatf("unit %0d addr %0d", u, addr));
        end else begin
            e.unit = u; e.is_if = 1'b1; e.data = exp_data; e.due = cyc + lat_of(u) + 1;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        if_req[u] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          base;
        logic [10:0] pat;
        mem_ready = 1'b0;
        for (int u = 0; u < NU; u++) begin
            rst[u] = 1'b1; if_req[u] = 1'b0; if_addr[u] = 32'd0;
            d_req[u] = 1'b0; d_we[u] = 1'b0; d_addr[u] = 32'd0; d_wdata[u] = 32'd0;
            wen_cnt[u] = 0; d_hold[u] = 32'd0;
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        idle(1);
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk("rst_if_valid", {31'd0, if_valid[u]}, 32'd0);
            chk("rst_d_valid", {31'd0, d_valid[u]}, 32'd0);
            chk("rst_if_rdata", if_rdata[u], 32'd0);
            chk("rst_d_rdata", d_rdata[u], 32'd0);
            chk("rst_mem_addr", mem_address[u], 32'd0);
            chk("rst_mem_din", mem_data_in[u], 32'd0);
            chk("rst_mem_wen", {31'd0, mem_wen[u]}, 32'd0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle(1);

        // MEM_LAT=3 load: address held three cycles, valid four cycles after grant.
        d_txn(1, 1'b0, 32'd7, 32'd0, 32'h0000_0077, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("lat3_addr_hold", mem_address[1], 32'd7);
            chk("lat3_no_wen", {31'd0, mem_wen[1]}, 32'd0);
        end
        idle(3);

        // Reset in the first hold cycle of a store abandons it.
        base = wen_cnt[1];
        d_txn(1, 1'b1, 32'd9, 32'h0000_DEAD, 32'd0, 1'b0);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        d_hold[1] = 32'd0;
        @(negedge clk);
        chk("rstmid_idle_addr", mem_address[1], 32'd0);
        chk("rstmid_wen", {31'd0, mem_wen[1]}, 32'd0);
        chk("rstmid_rdata_clr", d_rdata[1], 32'd0);
        idle(6);
        chk("rstmid_wen_count", wen_cnt[1] - base, 32'd0);
        chk("rstmid_mem9", mem[1][9], 32'h0000_0099);
        d_txn(1, 1'b0, 32'd9, 32'd0, 32'h0000_0099, 1'b1);
        idle(6);

        // MEM_LAT=1 fetch.
        if_txn(0, 32'd5, 32'h0000_0055);
        idle(3);

        // Store then load, single write strobe.
        base = wen_cnt[0];
        d_txn(0, 1'b1, 32'd3, 32'h0000_00A5, 32'd0, 1'b1);
        idle(3);
        chk("store_wen_once", wen_cnt[0] - base, 32'd1);
        d_txn(0, 1'b0, 32'd3, 32'd0, 32'h0000_00A5, 1'b1);
        idle(3);

        // Continuous contention: starvation forces every fifth grant to fetch.
        glog.delete();
        fork
            begin
                for (int k = 0; k < 9; k++)
                    d_txn(0, 1'b0, 32'd40 + k, 32'd0, 32'h1000_0000 + 32'd40 + k, 1'b1);
            end
            begin
                for (int j = 0; j < 2; j++)
                    if_txn(0, 32'd50 + j, 32'h1000_0000 + 32'd50 + j);
            end
        join
        idle(4);
        pat = 11'b010_0001_0000;
        chk("gnt_count", glog.size(), 32'd11);
        for (int k = 0; k < 11 && k < glog.size(); k++)
            chk($sformatf("gnt_order_%0d", k), {31'd0, glog[k]}, {31'd0, pat[k]});

        // Sweep: store i at word i, then read all back.
        base = wen_cnt[0];
        for (int i = 0; i < 32; i++) d_txn(0, 1'b1, i, i, 32'd0, 1'b1);
        idle(3);
        chk("sweep_wen_count", wen_cnt[0] - base, 32'd32);
        for (int i = 0; i < 32; i++) d_txn(0, 1'b0, i, 32'd0, i, 1'b1);
        idle(10);

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
